// File: rtl/cachepool_axi_rd_arbiter.sv
// Two-source AXI read arbiter with a single-entry AR buffer and R routing.
// Round-robin AR grant with per-source burst limits; R is routed by the ID MSB.
//
// Ports:
//   clk_i, rst_i          : clock, async active-high reset
//   s0_ar_*, s1_ar_*      : source AR channels (valid/ready, addr, id, len)
//   m_ar_*                : master AR channel, driven only from the buffer
//   m_r_*                 : master R channel (id MSB selects the source)
//   s0_r_*, s1_r_*        : source R channels (combinational pass-through)
//   busy_o                : request buffered or any burst outstanding
//   unexp_r_o             : sticky, last beat returned to an idle source
module cachepool_axi_rd_arbiter #(
    parameter int AddrWidth      = 48,
    parameter int DataWidth      = 512,
    parameter int IdWidth        = 6,
    parameter int MaxOutstanding = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 s0_ar_valid,
    output logic                 s0_ar_ready,
    input  logic [AddrWidth-1:0] s0_ar_addr,
    input  logic [IdWidth-1:0]   s0_ar_id,
    input  logic [7:0]           s0_ar_len,

    input  logic                 s1_ar_valid,
    output logic                 s1_ar_ready,
    input  logic [AddrWidth-1:0] s1_ar_addr,
    input  logic [IdWidth-1:0]   s1_ar_id,
    input  logic [7:0]           s1_ar_len,

    output logic                 m_ar_valid,
    input  logic                 m_ar_ready,
    output logic [AddrWidth-1:0] m_ar_addr,
    output logic [IdWidth:0]     m_ar_id,
    output logic [7:0]           m_ar_len,

    input  logic                 m_r_valid,
    output logic                 m_r_ready,
    input  logic [DataWidth-1:0] m_r_data,
    input  logic [IdWidth:0]     m_r_id,
    input  logic [1:0]           m_r_resp,
    input  logic                 m_r_last,

    output logic                 s0_r_valid,
    input  logic                 s0_r_ready,
    output logic [DataWidth-1:0] s0_r_data,
    output logic [IdWidth-1:0]   s0_r_id,
    output logic [1:0]           s0_r_resp,
    output logic                 s0_r_last,

    output logic                 s1_r_valid,
    input  logic                 s1_r_ready,
    output logic [DataWidth-1:0] s1_r_data,
    output logic [IdWidth-1:0]   s1_r_id,
    output logic [1:0]           s1_r_resp,
    output logic                 s1_r_last,

    output logic                 busy_o,
    output logic                 unexp_r_o
);

    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

    logic                 buf_valid;
    logic [AddrWidth-1:0] buf_addr;
    logic [IdWidth:0]     buf_id;
    logic [7:0]           buf_len;

    logic                 rr_ptr;
    logic [CntW-1:0]      cnt0;
    logic [CntW-1:0]      cnt1;
    logic                 unexp_q;

    logic elig0, elig1;
    logic loadable;
    logic gnt0, gnt1;
    logic r_sel;
    logic last0, last1;
    logic dec0, dec1;

    // Grant logic
    assign elig0    = s0_ar_valid && (cnt0 < CntMax);
    assign elig1    = s1_ar_valid && (cnt1 < CntMax);
    assign loadable = !buf_valid || m_ar_ready;

    // Held low during reset so no source sees a phantom accept.
    assign gnt0 = !rst_i && loadable && elig0 && (!elig1 || !rr_ptr);
    assign gnt1 = !rst_i && loadable && elig1 && (!elig0 ||  rr_ptr);

    assign s0_ar_ready = gnt0;
    assign s1_ar_ready = gnt1;

    assign m_ar_valid = buf_valid;
    assign m_ar_addr  = buf_addr;
    assign m_ar_id    = buf_id;
    assign m_ar_len   = buf_len;

    // R routing
    assign r_sel = m_r_id[IdWidth];

    assign s0_r_valid = m_r_valid && !r_sel;
    assign s1_r_valid = m_r_valid &&  r_sel;
    assign m_r_ready  = r_sel ? s1_r_ready : s0_r_ready;

    assign s0_r_data = m_r_data;
    assign s1_r_data = m_r_data;
    assign s0_r_id   = m_r_id[IdWidth-1:0];
    assign s1_r_id   = m_r_id[IdWidth-1:0];
    assign s0_r_resp = m_r_resp;
    assign s1_r_resp = m_r_resp;
    assign s0_r_last = m_r_last;
    assign s1_r_last = m_r_last;

    assign last0 = s0_r_valid && s0_r_ready && m_r_last;
    assign last1 = s1_r_valid && s1_r_ready && m_r_last;

    // A last beat to an idle source is flagged, never counted.
    assign dec0 = last0 && (cnt0 != '0);
    assign dec1 = last1 && (cnt1 != '0);

    // AR buffer; a grant in the handshake cycle refills it back-to-back.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_id    <= '0;
            buf_len   <= '0;
        end else if (gnt0) begin
            buf_valid <= 1'b1;
            buf_addr  <= s0_ar_addr;
            buf_id    <= {1'b0, s0_ar_id};
            buf_len   <= s0_ar_len;
        end else if (gnt1) begin
            buf_valid <= 1'b1;
            buf_addr  <= s1_ar_addr;
            buf_id    <= {1'b1, s1_ar_id};
            buf_len   <= s1_ar_len;
        end else if (m_ar_ready) begin
            buf_valid <= 1'b0;
        end
    end

    // Round-robin pointer favours the source not just granted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr <= 1'b0;
        end else if (gnt0) begin
            rr_ptr <= 1'b1;
        end else if (gnt1) begin
            rr_ptr <= 1'b0;
        end
    end

    // Outstanding counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            case ({gnt0, dec0})
                2'b10:   cnt0 <= cnt0 + 1'b1;
                2'b01:   cnt0 <= cnt0 - 1'b1;
                default: cnt0 <= cnt0;
            endcase
            case ({gnt1, dec1})
                2'b10:   cnt1 <= cnt1 + 1'b1;
                2'b01:   cnt1 <= cnt1 - 1'b1;
                default: cnt1 <= cnt1;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            unexp_q <= 1'b0;
        end else if ((last0 && cnt0 == '0) || (last1 && cnt1 == '0)) begin
            unexp_q <= 1'b1;
        end
    end

    assign unexp_r_o = unexp_q;
    assign busy_o    = buf_valid || (cnt0 != '0) || (cnt1 != '0);

endmodule
